floating: RTL and testbench
===========================

# floating

Sequential IEEE-754 single-precision multiplier. Operands are captured while `i_load` is high. After `i_load` falls, an iterative 24×24 shift-add mantissa multiply runs, followed by normalisation and round-to-nearest-even. The registered product appears on `o_res` and is held there. The block is a standalone arithmetic core; it has no handshake beyond load.

## Interface
- Parameters: none. Format constants live in the package.
- `i_clk` in 1: the single clock; all state changes on its rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_load` in 1: operand capture and restart, level-sensitive.
- `i_a` in 32: multiplicand (binary32).
- `i_b` in 32: multiplier (binary32).
- `o_res` out 32: product (binary32), registered.

## Operation
- FSM states: IDLE, LOAD, MUL, NORM, ROUND, DONE.
- Reset:
  - state is IDLE, `o_res` = 0, all datapath registers are 0.
  - `i_rst` dominates `i_load`.
- `i_load` = 1 on any edge, in any state:
  - register `i_a`/`i_b` and go to LOAD;
  - clear `o_res` to 0;
  - an in-flight operation is aborted.
- In LOAD with `i_load` = 0:
  - unpack both operands;
  - resolve special cases;
  - enter MUL, or go straight to DONE for special cases.
- Special cases, in priority order:
  - NaN input, or Inf×0: output 0x7FC00000.
  - Inf × nonzero: output signed Inf.
  - Zero × finite: output signed zero. Sign is always `a[31]^b[31]`, so 0×(+x) = 0x00000000 and (−x)×0 = 0x80000000.
- MUL:
  - 24 iterations of shift-add over 24-bit significands, producing a 48-bit product;
  - the hidden bit is 1 for normal inputs and 0 for subnormals; subnormal exponent is treated as 1.
- Exponent:
  - unbiased sum `ea + eb − 127`, carried in 10-bit signed arithmetic;
  - incremented by 1 if product bit 47 is set.
- NORM:
  - left-normalise subnormal-input products;
  - if the exponent ≤ 0, right-shift into the subnormal range, collecting the sticky bit (saturate the shift at 26).
- ROUND:
  - round-to-nearest-even on guard/round/sticky;
  - a mantissa carry-out increments the exponent;
  - a subnormal that rounds up to 2^-126 becomes the smallest normal;
  - exponent ≥ 255 after rounding gives signed Inf;
  - a total underflow that rounds to 0 gives signed zero.
- DONE: `o_res` written once and held until the next load or reset.

## Timing
- Count from the first rising edge at which `i_load` = 0 in LOAD (edge 1).
- Normal path:
  - edge 1: unpack;
  - edges 2–25: MUL;
  - edge 26: NORM;
  - edge 27: ROUND;
  - edge 28: `o_res` valid.
- Special cases: `o_res` valid at edge 2.
- `o_res` = 0 from a load edge until the result edge.
- `o_res` is stable from the result edge until the next load or reset; no glitches.
- Reset mid-operation: `o_res` is 0 immediately and the FSM returns to IDLE.
- Operands may change freely once `i_load` is low.
- `i_load` held high for many cycles: the operands captured on the last load-high edge are used.

## Configuration
- `FLOATING_SUBNORMAL_EN`:
  - defined: gradual underflow; subnormal inputs and outputs are handled as in Operation.
  - undefined: subnormal inputs are treated as signed zero, and any result below 2^-126 after rounding flushes to signed zero.
- The default build defines `FLOATING_SUBNORMAL_EN`.

## Structure
- Package `floating_pkg` holds:
  - field widths (sign 1, exponent 8, mantissa 23);
  - BIAS = 127;
  - QNAN = 0x7FC00000;
  - POS_INF = 0x7F800000;
  - the FSM state enum;
  - the MUL iteration count (24).
- One sub-module, `floating_seq_mul`: 24×24 iterative shift-add multiplier with start/done signals.
- Unpack, normalise, round and pack stay in the top level.

## Test plan
- Normal with rounding:
  - 0x49072340 × 0x44520000 → 0x4DDDB5D5;
  - 0xC3818000 × 0x49072340 → 0xCD08B8AA;
  - 0xCE8EF06B × 0xCEEF06AA → 0x5E05762C.
- Identity and signed zero:
  - 0x3F800000 × 0x4EA0C8E4 → 0x4EA0C8E4;
  - 0x00000000 × 0x4EA0C8E4 → 0x00000000;
  - 0xCE8EF06B × 0x00000000 → 0x80000000.
- Near-two mantissas:
  - 0x3FFFFFF0 × 0x41A00000 → 0x421FFFF6;
  - 0xBFFFFFFF × 0x41A00000 → 0xC21FFFFF.
- Overflow:
  - 0x3FFFFFF0 × 0x7F200000 → 0x7F800000;
  - 0xBFFFFFFF × 0x7F200000 → 0xFF800000.
- Subnormal output, with `FLOATING_SUBNORMAL_EN`: 0x35D00998 × 0x00800000 → 0x0000000D. Without the macro → 0x00000000.
- Control:
  - assert reset mid-MUL → `o_res` = 0 immediately;
  - reload mid-MUL with new operands → new result at exactly edge 28, old result never appears;
  - Inf×0 → 0x7FC00000 at edge 2.

Source files
------------

// File: rtl/floating_pkg.sv
// floating_pkg: binary32 format constants, FSM state type and helpers
// shared by the sequential multiplier core and its shift-add engine.
package floating_pkg;

  localparam int unsigned SIGN_W    = 1;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MANT_W    = 23;
  localparam int unsigned SIG_W     = MANT_W + 1;
  localparam int unsigned PROD_W    = 2 * SIG_W;
  localparam int unsigned EXPI_W    = 10;
  localparam int unsigned MUL_ITERS = 24;
  localparam int unsigned RSH_SAT   = 26;
  localparam int unsigned BIAS      = 127;

  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [31:0]      POS_INF = 32'h7F80_0000;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    NORM,
    ROUND,
    DONE
  } state_t;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  // Leading-zero count of a raw product (PROD_W when all zero).
  function automatic logic [5:0] lzc_prod(input logic [PROD_W-1:0] v);
    logic [5:0] n;
    n = 6'(PROD_W);
    for (int unsigned i = 0; i < PROD_W; i++) begin
      if (v[i]) n = 6'(PROD_W - 1 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/floating_seq_mul.sv
// floating_seq_mul: 24x24 iterative shift-add significand multiplier.
// One partial product per clock; o_done is high during the final iteration
// so the product is complete on o_prod right after that edge.
module floating_seq_mul
  import floating_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_start,
  input  logic [SIG_W-1:0]  i_a,
  input  logic [SIG_W-1:0]  i_b,
  output logic              o_done,
  output logic [PROD_W-1:0] o_prod
);

  localparam logic [4:0] LAST = 5'(MUL_ITERS - 1);

  logic [PROD_W-1:0] r_acc;
  logic [PROD_W-1:0] r_mcand;
  logic [SIG_W-1:0]  r_mplier;
  logic [4:0]        r_cnt;
  logic              r_busy;

  // Shift-add iteration: add shifted multiplicand when the current multiplier bit is set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_clr) begin
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{SIG_W{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 5'd1;
      if (r_cnt == LAST) r_busy <= 1'b0;
    end
  end

  assign o_done = r_busy && (r_cnt == LAST);
  assign o_prod = r_acc;

endmodule

// File: rtl/floating.sv
// floating: sequential IEEE-754 binary32 multiplier (round to nearest even).
// Build option FLOATING_SUBNORMAL_EN: when defined, subnormal inputs and
// outputs use gradual underflow; when undefined, subnormal inputs act as
// signed zero and results below 2^-126 after rounding flush to signed zero.
module floating
  import floating_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_res
);

  state_t r_state;
  state_t w_next;

  logic [31:0]              r_a;
  logic [31:0]              r_b;
  logic [31:0]              r_pack;
  logic [31:0]              r_res;
  logic                     r_sign;
  logic signed [EXPI_W-1:0] r_exp;
  logic [SIG_W-1:0]         r_sig;
  logic                     r_g;
  logic                     r_r;
  logic                     r_s;

  // unpack / special-case signals
  fp32_t                    w_fa;
  fp32_t                    w_fb;
  logic                     w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic                     w_sign;
  logic                     w_special;
  logic [31:0]              w_special_res;
  logic [SIG_W-1:0]         w_sig_a;
  logic [SIG_W-1:0]         w_sig_b;
  logic signed [EXPI_W-1:0] w_exp_a;
  logic signed [EXPI_W-1:0] w_exp_b;
  logic signed [EXPI_W-1:0] w_exp_sum;

  // multiplier interface
  logic                     w_start;
  logic                     w_done;
  logic [PROD_W-1:0]        w_prod;

  // normalise signals
  logic [5:0]               w_lz;
  logic [PROD_W-1:0]        w_lm;
  logic signed [EXPI_W-1:0] w_en;
  logic signed [EXPI_W-1:0] w_d;
  logic [4:0]               w_rsh;
  logic [PROD_W-1:0]        w_nm;
  logic [RSH_SAT-1:0]       w_out;
  logic signed [EXPI_W-1:0] w_nexp;

  // round signals
  logic                     w_up;
  logic [SIG_W:0]           w_sum;
  logic signed [EXPI_W-1:0] w_fexp;
  logic [MANT_W-1:0]        w_frac;
  logic [31:0]              w_rnd;

  assign w_fa  = r_a;
  assign w_fb  = r_b;
  assign o_res = r_res;

  floating_seq_mul u_mul (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (i_load),
    .i_start (w_start),
    .i_a     (w_sig_a),
    .i_b     (w_sig_b),
    .o_done  (w_done),
    .o_prod  (w_prod)
  );

  // Unpack captured operands and classify special cases by priority.
  always_comb begin
    w_a_nan = (w_fa.exp == EXP_MAX) && (w_fa.mant != '0);
    w_b_nan = (w_fb.exp == EXP_MAX) && (w_fb.mant != '0);
    w_a_inf = (w_fa.exp == EXP_MAX) && (w_fa.mant == '0);
    w_b_inf = (w_fb.exp == EXP_MAX) && (w_fb.mant == '0);
`ifdef FLOATING_SUBNORMAL_EN
    w_a_zero = (w_fa.exp == '0) && (w_fa.mant == '0);
    w_b_zero = (w_fb.exp == '0) && (w_fb.mant == '0);
`else
    w_a_zero = (w_fa.exp == '0);
    w_b_zero = (w_fb.exp == '0);
`endif
    w_sign    = w_fa.sign[0] ^ w_fb.sign[0];
    w_sig_a   = {(w_fa.exp != '0), w_fa.mant};
    w_sig_b   = {(w_fb.exp != '0), w_fb.mant};
    w_exp_a   = (w_fa.exp == '0) ? 10'sd1 : $signed({2'b00, w_fa.exp});
    w_exp_b   = (w_fb.exp == '0) ? 10'sd1 : $signed({2'b00, w_fb.exp});
    w_exp_sum = w_exp_a + w_exp_b - $signed(10'(BIAS));

    w_special     = 1'b1;
    w_special_res = QNAN;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_special_res = QNAN;
    end else if (w_a_inf || w_b_inf) begin
      w_special_res = {w_sign, EXP_MAX, {MANT_W{1'b0}}};
    end else if (w_a_zero || w_b_zero) begin
      w_special_res = {w_sign, 31'b0};
    end else begin
      w_special = 1'b0;
    end
  end

  // Normalise: left-justify the product, then right-shift into the
  // subnormal range with sticky collection when the exponent is <= 0.
  // Left-justifying first makes the bit-47 increment and the subnormal-input
  // renormalisation one formula: exp + 1 - lz.
  always_comb begin
    w_lz   = lzc_prod(w_prod);
    w_lm   = w_prod << w_lz;
    w_en   = r_exp + 10'sd1 - $signed({4'b0000, w_lz});
    w_d    = 10'sd1 - w_en;
    w_rsh  = '0;
    w_nexp = w_en;
    if (w_en <= 10'sd0) begin
      w_rsh  = (w_d > $signed(10'(RSH_SAT))) ? 5'(RSH_SAT) : w_d[4:0];
      w_nexp = 10'sd0;
    end
    {w_nm, w_out} = {w_lm, {RSH_SAT{1'b0}}} >> w_rsh;
  end

  // Round to nearest even and pack, handling carry-out, subnormal promotion,
  // overflow to Inf and (optionally) flush of sub-2^-126 results.
  always_comb begin
    w_up  = r_g & (r_r | r_s | r_sig[0]);
    w_sum = {1'b0, r_sig} + {{SIG_W{1'b0}}, w_up};
    if (r_exp == 10'sd0) begin
      w_fexp = $signed({9'b0, w_sum[SIG_W-1]});
      w_frac = w_sum[MANT_W-1:0];
    end else if (w_sum[SIG_W]) begin
      w_fexp = r_exp + 10'sd1;
      w_frac = w_sum[MANT_W:1];
    end else begin
      w_fexp = r_exp;
      w_frac = w_sum[MANT_W-1:0];
    end

    if (w_fexp >= 10'sd255) begin
      w_rnd = {r_sign, EXP_MAX, {MANT_W{1'b0}}};
`ifndef FLOATING_SUBNORMAL_EN
    end else if (w_fexp == 10'sd0) begin
      w_rnd = {r_sign, 31'b0};
`endif
    end else begin
      w_rnd = {r_sign, w_fexp[EXP_W-1:0], w_frac};
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a load level restarts from any state.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    if (i_load) begin
      w_next = LOAD;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_special) begin
            w_next = DONE;
          end else begin
            w_next  = MUL;
            w_start = 1'b1;
          end
        end
        MUL:     if (w_done) w_next = NORM;
        NORM:    w_next = ROUND;
        ROUND:   w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Datapath registers: capture, per-stage results and the held output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_pack <= '0;
      r_res  <= '0;
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_sig  <= '0;
      r_g    <= 1'b0;
      r_r    <= 1'b0;
      r_s    <= 1'b0;
    end else if (i_load) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_res <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          r_sign <= w_sign;
          r_exp  <= w_exp_sum;
          if (w_special) r_pack <= w_special_res;
        end
        NORM: begin
          r_sig <= w_nm[PROD_W-1 -: SIG_W];
          r_g   <= w_nm[PROD_W-SIG_W-1];
          r_r   <= w_nm[PROD_W-SIG_W-2];
          r_s   <= (|w_nm[PROD_W-SIG_W-3:0]) | (|w_out);
          r_exp <= w_nexp;
        end
        ROUND:   r_pack <= w_rnd;
        DONE:    r_res  <= r_pack;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_floating.sv
// tb_floating: self-checking bench for the sequential binary32 multiplier.
// Expected products come from an exact-integer rounding model of IEEE-754.
module tb_floating;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_load;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [31:0] o_res;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

`ifdef FLOATING_SUBNORMAL_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  floating dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (i_load),
    .i_a    (i_a),
    .i_b    (i_b),
    .o_res  (o_res)
  );

  always #5 i_clk = ~i_clk;

  function automatic bit f_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic bit f_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 0);
  endfunction

  function automatic bit f_zero(input logic [31:0] x);
    return (x[30:23] == 8'h00) && ((x[22:0] == 0) || !SUB);
  endfunction

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return f_nan(a) || f_nan(b) || f_inf(a) || f_inf(b) || f_zero(a) || f_zero(b);
  endfunction

  // Exact product p * 2^e0, rounded once to binary32 (RNE).
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    longint unsigned ma, mb, p, m, rem, half;
    int ea, eb, e0, n, sh, lsb;
    s = a[31] ^ b[31];
    if (f_nan(a) || f_nan(b) || (f_inf(a) && f_zero(b)) || (f_inf(b) && f_zero(a)))
      return 32'h7FC00000;
    if (f_inf(a) || f_inf(b)) return {s, 8'hFF, 23'h0};
    if (f_zero(a) || f_zero(b)) return {s, 31'h0};
    ma = 64'(a[22:0]);
    mb = 64'(b[22:0]);
    if (a[30:23] != 0) ma += 64'd1 << 23;
    if (b[30:23] != 0) mb += 64'd1 << 23;
    ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
    e0 = ea + eb - 254 - 46;
    p = ma * mb;
    n = 63;
    while (n > 0 && !p[n]) n--;
    sh = n - 23;
    if (n + e0 < -126) sh = -149 - e0;
    if (sh <= 0) begin
      m = p << (-sh);
    end else if (sh > 62) begin
      m = 0;
    end else begin
      m    = p >> sh;
      rem  = p & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m++;
    end
    lsb = e0 + sh;
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      lsb++;
    end
    if (m >= (64'd1 << 23)) begin
      if (lsb + 150 >= 255) return {s, 8'hFF, 23'h0};
      return {s, 8'(lsb + 150), m[22:0]};
    end
    if (!SUB) return {s, 31'h0};
    return {s, 8'h00, m[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic       s;
    logic [7:0] e;
    logic [22:0] m;
    s = 1'($urandom);
    m = 23'($urandom);
    case ($urandom_range(0, 9))
      0: begin e = 8'h00; m = '0; end
      1: begin e = 8'hFF; m = '0; end
      2: begin e = 8'hFF; if (m == 0) m = 23'd1; end
      3: e = 8'h00;
      4: e = 8'($urandom_range(200, 254));
      5: e = 8'($urandom_range(1, 40));
      6: e = 8'($urandom_range(80, 120));
      default: e = 8'($urandom_range(64, 190));
    endcase
    return {s, e, m};
  endfunction

  // Load (optionally held for several cycles), then check o_res is 0 up to
  // the result edge and equals exp exactly at edge 2 or 28.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int hold, input string name);
    int lat;
    lat = is_special(a, b) ? 2 : 28;
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      i_load = 1'b1;
      i_a    = (h == hold - 1) ? a : $urandom;
      i_b    = (h == hold - 1) ? b : $urandom;
    end
    @(negedge i_clk);
    n_checks++;
    if (o_res !== 32'h0) begin
      n_fail++;
      $display("FAIL %s load_clear: got %h want 00000000", name, o_res);
    end
    i_load = 1'b0;
    i_a    = $urandom;
    i_b    = $urandom;
    for (int k = 1; k <= lat; k++) begin
      @(posedge i_clk);
      #1;
      n_checks++;
      if (k < lat) begin
        if (o_res !== 32'h0) begin
          n_fail++;
          $display("FAIL %s early edge %0d: got %h want 00000000", name, k, o_res);
        end
      end else if (o_res !== exp) begin
        n_fail++;
        $display("FAIL %s a=%h b=%h edge %0d: got %h want %h", name, a, b, k, o_res, exp);
      end
    end
  endtask

  task automatic test_reset();
    i_rst  = 1'b1;
    i_load = 1'b1;
    i_a    = 32'h3F800000;
    i_b    = 32'h3F800000;
    repeat (3) @(negedge i_clk);
    n_checks++;
    if (o_res !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_value: got %h want 00000000", o_res);
    end
    i_load = 1'b0;
    i_rst  = 1'b0;
    repeat (35) @(negedge i_clk);
    n_checks++;
    if (o_res !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_idle: got %h want 00000000", o_res);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va [12];
    logic [31:0] vb [12];
    logic [31:0] ve [12];
    va[0]  = 32'h49072340; vb[0]  = 32'h44520000; ve[0]  = 32'h4DDDB5D5;
    va[1]  = 32'hC3818000; vb[1]  = 32'h49072340; ve[1]  = 32'hCD08B8AA;
    va[2]  = 32'hCE8EF06B; vb[2]  = 32'hCEEF06AA; ve[2]  = 32'h5E05762C;
    va[3]  = 32'h3F800000; vb[3]  = 32'h4EA0C8E4; ve[3]  = 32'h4EA0C8E4;
    va[4]  = 32'h00000000; vb[4]  = 32'h4EA0C8E4; ve[4]  = 32'h00000000;
    va[5]  = 32'hCE8EF06B; vb[5]  = 32'h00000000; ve[5]  = 32'h80000000;
    va[6]  = 32'h3FFFFFF0; vb[6]  = 32'h41A00000; ve[6]  = 32'h421FFFF6;
    va[7]  = 32'hBFFFFFFF; vb[7]  = 32'h41A00000; ve[7]  = 32'hC21FFFFF;
    va[8]  = 32'h3FFFFFF0; vb[8]  = 32'h7F200000; ve[8]  = 32'h7F800000;
    va[9]  = 32'hBFFFFFFF; vb[9]  = 32'h7F200000; ve[9]  = 32'hFF800000;
    va[10] = 32'h35D00998; vb[10] = 32'h00800000; ve[10] = SUB ? 32'h0000000D : 32'h00000000;
    va[11] = 32'h7F800000; vb[11] = 32'h00000000; ve[11] = 32'h7FC00000;
    for (int i = 0; i < 12; i++) run_op(va[i], vb[i], ve[i], 1, "vector");
  endtask

  task automatic test_special_timing();
    run_op(32'h7FC12345, 32'h3F800000, ref_mul(32'h7FC12345, 32'h3F800000), 1, "nan");
    run_op(32'hFF800000, 32'h40000000, ref_mul(32'hFF800000, 32'h40000000), 1, "neg_inf");
    run_op(32'h00000000, 32'hC0400000, ref_mul(32'h00000000, 32'hC0400000), 1, "zero_neg");
    run_op(32'h00000000, 32'h7F800000, ref_mul(32'h00000000, 32'h7F800000), 1, "zero_inf");
  endtask

  task automatic test_hold_result();
    logic [31:0] e;
    e = ref_mul(32'h40490FDB, 32'hC02DF854);
    run_op(32'h40490FDB, 32'hC02DF854, e, 1, "hold_src");
    for (int k = 0; k < 6; k++) begin
      @(posedge i_clk);
      #1;
      n_checks++;
      if (o_res !== e) begin
        n_fail++;
        $display("FAIL hold_result cycle %0d: got %h want %h", k, o_res, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    @(negedge i_clk);
    i_load = 1'b1;
    i_a    = 32'h49072340;
    i_b    = 32'h44520000;
    @(negedge i_clk);
    i_load = 1'b0;
    repeat (12) @(posedge i_clk);
    #3 i_rst = 1'b1;
    #1;
    n_checks++;
    if (o_res !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_mul: got %h want 00000000", o_res);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 35; k++) begin
      @(posedge i_clk);
      #1;
      if (o_res !== 32'h0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_abort: got %h want 00000000", o_res);
    end
    run_op(32'h49072340, 32'h44520000, 32'h4DDDB5D5, 1, "pre_rst_held");
    #2 i_rst = 1'b1;
    #1;
    n_checks++;
    if (o_res !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_held_result: got %h want 00000000", o_res);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_reload();
    @(negedge i_clk);
    i_load = 1'b1;
    i_a    = 32'h49072340;
    i_b    = 32'h44520000;
    @(negedge i_clk);
    i_load = 1'b0;
    repeat (10) @(negedge i_clk);
    run_op(32'hC3818000, 32'h49072340, 32'hCD08B8AA, 1, "reload_mid_mul");
  endtask

  task automatic test_load_held();
    run_op(32'hCE8EF06B, 32'hCEEF06AA, 32'h5E05762C, 6, "load_held");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = rand_op();
      b = rand_op();
      run_op(a, b, ref_mul(a, b), ($urandom_range(0, 3) == 0) ? 3 : 1, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_vectors();
    test_special_timing();
    test_hold_result();
    test_reset_mid();
    test_reload();
    test_load_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
